// File: rtl/pwm_to_angle.sv
// Decodes the absolute encoder's PWM angle output: measures high time and period of each
// frame, then normalises the duty cycle to a 4351-unit frame with a sequential divider.
module pwm_to_angle #(
    parameter int CNT_W       = 20,
    parameter int MIN_PERIOD  = 1000,
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic        reset_n,
    input  logic        clock,
    input  logic        enable,
    input  logic        pwm_in,
    output logic [11:0] angle,
    output logic        angle_valid,
    output logic        locked,
    output logic        fault,
    output logic        overrun
);
    localparam int NW   = CNT_W + 32'sd13;
    localparam int IT_W = $clog2(NW);
    localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] MIN_P       = CNT_W'(MIN_PERIOD);
    localparam logic [CNT_W-1:0] WD_LAST     = CNT_W'(TIMEOUT_CYC - 32'sd1);
    localparam logic [IT_W-1:0]  IT_LAST     = IT_W'(NW - 32'sd1);
    localparam logic [IT_W-1:0]  IT_ONE      = {{(IT_W-1){1'b0}}, 1'b1};
    localparam logic [NW-1:0]    FRAME_UNITS = {{CNT_W{1'b0}}, 13'd4351};

    typedef enum logic [1:0] {
        ST_SYNC = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2
    } state_e;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] r;
        if (v == CNT_MAX) r = v;
        else              r = v + CNT_ONE;
        return r;
    endfunction

    // Strip the 128-unit header and clamp into the 12-bit data range.
    function automatic logic [11:0] clamp_angle(input logic [12:0] q);
        logic [11:0] r;
        logic [12:0] t;
        t = q - 13'd128;
        if (q < 13'd128)       r = 12'd0;
        else if (q > 13'd4223) r = 12'd4095;
        else                   r = t[11:0];
        return r;
    endfunction

    logic             sync1_q, sync_q, sync_dly_q;
    logic             rise_s, fall_s, close_s, timeout_s, accept_s, done_s;
    state_e           state_q, state_d;
    logic [CNT_W-1:0] hi_cnt_q, hi_cnt_d, per_cnt_q, per_cnt_d, wd_q, wd_d;
    logic             busy_q, busy_d;
    logic [IT_W-1:0]  it_q, it_d;
    logic [NW-1:0]    num_q, num_d;
    logic [CNT_W-1:0] den_q, den_d, rem_q, rem_d, rem_sub_s;
    logic [11:0]      quo_q, quo_d;
    logic [CNT_W:0]   trial_s;
    logic             qbit_s;
    logic [12:0]      q_s;
    logic [11:0]      angle_q, angle_d;
    logic             valid_q, valid_d, locked_q, locked_d, fault_q, fault_d, overrun_q, overrun_d;

    assign rise_s    = sync_q & ~sync_dly_q;
    assign fall_s    = ~sync_q & sync_dly_q;
    assign timeout_s = enable & ~rise_s & (wd_q == WD_LAST);
    assign accept_s  = close_s & (per_cnt_q >= MIN_P) & ~busy_q;
    assign trial_s   = {rem_q, num_q[NW-1]};
    assign qbit_s    = (trial_s >= {1'b0, den_q});
    assign rem_sub_s = trial_s[CNT_W-1:0] - den_q;
    assign q_s       = {quo_q, qbit_s};

    assign angle       = angle_q;
    assign angle_valid = valid_q;
    assign locked      = locked_q;
    assign fault       = fault_q;
    assign overrun     = overrun_q;

    // Two-flop synchroniser plus one delay stage for edge detection.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q    <= 1'b0;
            sync_q     <= 1'b0;
            sync_dly_q <= 1'b0;
        end else begin
            sync1_q    <= pwm_in;
            sync_q     <= sync1_q;
            sync_dly_q <= sync_q;
        end
    end

    // Measure FSM, duration counters and rising-edge watchdog.
    always_comb begin
        state_d   = state_q;
        hi_cnt_d  = hi_cnt_q;
        per_cnt_d = per_cnt_q;
        close_s   = 1'b0;
        if (!enable) wd_d = {CNT_W{1'b0}};
        else if (rise_s) wd_d = {CNT_W{1'b0}};
        else wd_d = sat_inc(wd_q);
        if (!enable || timeout_s) begin
            state_d   = ST_SYNC;
            hi_cnt_d  = {CNT_W{1'b0}};
            per_cnt_d = {CNT_W{1'b0}};
        end else begin
            case (state_q)
                ST_SYNC: begin
                    if (rise_s) begin
                        state_d   = ST_HIGH;
                        hi_cnt_d  = CNT_ONE;
                        per_cnt_d = CNT_ONE;
                    end else begin
                        hi_cnt_d  = {CNT_W{1'b0}};
                        per_cnt_d = {CNT_W{1'b0}};
                    end
                end
                ST_HIGH: begin
                    if (fall_s) begin
                        state_d   = ST_LOW;
                        per_cnt_d = sat_inc(per_cnt_q);
                    end else begin
                        hi_cnt_d  = sat_inc(hi_cnt_q);
                        per_cnt_d = sat_inc(per_cnt_q);
                    end
                end
                ST_LOW: begin
                    // The closing edge cycle is the first cycle of the next frame.
                    if (rise_s) begin
                        close_s   = 1'b1;
                        state_d   = ST_HIGH;
                        hi_cnt_d  = CNT_ONE;
                        per_cnt_d = CNT_ONE;
                    end else begin
                        per_cnt_d = sat_inc(per_cnt_q);
                    end
                end
                default: begin
                    state_d   = ST_SYNC;
                    hi_cnt_d  = {CNT_W{1'b0}};
                    per_cnt_d = {CNT_W{1'b0}};
                end
            endcase
        end
    end

    // Restoring divider: one quotient bit per clock, MSB first.
    always_comb begin
        num_d  = num_q;
        den_d  = den_q;
        rem_d  = rem_q;
        quo_d  = quo_q;
        it_d   = it_q;
        busy_d = busy_q;
        done_s = 1'b0;
        if (!enable) begin
            busy_d = 1'b0;
        end else if (accept_s) begin
            num_d  = {13'd0, hi_cnt_q} * FRAME_UNITS;
            den_d  = per_cnt_q;
            rem_d  = {CNT_W{1'b0}};
            quo_d  = 12'd0;
            it_d   = {IT_W{1'b0}};
            busy_d = 1'b1;
        end else if (busy_q) begin
            num_d = {num_q[NW-2:0], 1'b0};
            quo_d = {quo_q[10:0], qbit_s};
            if (qbit_s) rem_d = rem_sub_s;
            else        rem_d = trial_s[CNT_W-1:0];
            it_d = it_q + IT_ONE;
            if (it_q == IT_LAST) begin
                busy_d = 1'b0;
                done_s = 1'b1;
            end else begin
                busy_d = 1'b1;
            end
        end else begin
            busy_d = 1'b0;
        end
    end

    // Published angle and status flags.
    always_comb begin
        angle_d   = angle_q;
        valid_d   = 1'b0;
        locked_d  = locked_q;
        fault_d   = fault_q;
        overrun_d = close_s & (per_cnt_q >= MIN_P) & busy_q;
        if (!enable) begin
            locked_d = 1'b0;
        end else if (done_s) begin
            angle_d  = clamp_angle(q_s);
            valid_d  = 1'b1;
            locked_d = 1'b1;
            fault_d  = 1'b0;
        end else if (timeout_s) begin
            fault_d  = 1'b1;
            locked_d = 1'b0;
        end else begin
            locked_d = locked_q;
        end
    end

    // State registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_SYNC;
            hi_cnt_q  <= {CNT_W{1'b0}};
            per_cnt_q <= {CNT_W{1'b0}};
            wd_q      <= {CNT_W{1'b0}};
            busy_q    <= 1'b0;
            it_q      <= {IT_W{1'b0}};
            num_q     <= {NW{1'b0}};
            den_q     <= {CNT_W{1'b0}};
            rem_q     <= {CNT_W{1'b0}};
            quo_q     <= 12'd0;
            angle_q   <= 12'd0;
            valid_q   <= 1'b0;
            locked_q  <= 1'b0;
            fault_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            hi_cnt_q  <= hi_cnt_d;
            per_cnt_q <= per_cnt_d;
            wd_q      <= wd_d;
            busy_q    <= busy_d;
            it_q      <= it_d;
            num_q     <= num_d;
            den_q     <= den_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            angle_q   <= angle_d;
            valid_q   <= valid_d;
            locked_q  <= locked_d;
            fault_q   <= fault_d;
            overrun_q <= overrun_d;
        end
    end
endmodule

// File: tb/tb_pwm_to_angle.sv
// Self-checking bench for pwm_to_angle: frame-level reference model predicts every strobe,
// angle and overrun pulse; PWM is driven one cycle-aligned transition at a time.
module tb_pwm_to_angle;
    localparam int CNT_W    = 20;
    localparam int MIN_P    = 20;
    localparam int TMO      = 6000;
    localparam int LAT      = CNT_W + 16;  // drive of closing edge to visible strobe
    localparam int BUSY_WIN = CNT_W + 13;  // closes this close after an accepted one overrun

    logic        reset_n, clock, enable, pwm_in;
    logic [11:0] angle;
    logic        angle_valid, locked, fault, overrun;

    pwm_to_angle #(.CNT_W(CNT_W), .MIN_PERIOD(MIN_P), .TIMEOUT_CYC(TMO)) dut (
        .reset_n(reset_n), .clock(clock), .enable(enable), .pwm_in(pwm_in),
        .angle(angle), .angle_valid(angle_valid), .locked(locked), .fault(fault),
        .overrun(overrun)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct { int c; logic [11:0] a; } ev_t;
    ev_t         ev_q[$];
    int          ov_q[$];
    int          cyc, n_cmp, n_fail;
    logic [11:0] mdl_angle;
    bit          have_prev;
    int          prev_rise, fall_cyc, last_acc;

    function automatic logic [11:0] model_angle(input int hi, input int per);
        longint q;
        q = (longint'(hi) * 4351) / per;
        q = q % 8192;
        if (q < 128) return 12'd0;
        if (q - 128 > 4095) return 12'd4095;
        return 12'(q - 128);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0d want=%0d", name, cyc, act, exp);
        end
    endtask

    task automatic compare();
        bit ev, eo;
        logic [11:0] ea;
        ev = 1'b0; eo = 1'b0; ea = 12'd0;
        while (ev_q.size() > 0 && ev_q[0].c < cyc) void'(ev_q.pop_front());
        if (ev_q.size() > 0 && ev_q[0].c == cyc) begin
            ev = 1'b1; ea = ev_q[0].a; void'(ev_q.pop_front());
        end
        while (ov_q.size() > 0 && ov_q[0] < cyc) void'(ov_q.pop_front());
        if (ov_q.size() > 0 && ov_q[0] == cyc) begin
            eo = 1'b1; void'(ov_q.pop_front());
        end
        if (!reset_n) mdl_angle = 12'd0;
        else if (ev) mdl_angle = ea;
        chk("angle_valid", angle_valid, ev);
        chk("angle", angle, mdl_angle);
        chk("overrun", overrun, eo);
        if (ev) begin
            chk("locked_at_valid", locked, 1);
            chk("fault_at_valid", fault, 0);
        end
    endtask

    task automatic tick();
        @(negedge clock);
        compare();
        @(posedge clock);
        cyc++;
        #1;
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) tick();
    endtask

    task automatic drive_pwm(input logic v);
        int hi, per;
        pwm_in = v;
        if (v) begin
            if (have_prev) begin
                hi  = fall_cyc - prev_rise;
                per = cyc - prev_rise;
                if (per < MIN_P) begin
                    hi = 0;
                end else if (cyc - last_acc <= BUSY_WIN) begin
                    ov_q.push_back(cyc + 3);
                end else begin
                    last_acc = cyc;
                    ev_q.push_back('{cyc + LAT, model_angle(hi, per)});
                end
            end
            have_prev = 1'b1;
            prev_rise = cyc;
        end else begin
            fall_cyc = cyc;
        end
    endtask

    task automatic frame(input int hi, input int per);
        drive_pwm(1'b1);
        wait_cyc(hi);
        drive_pwm(1'b0);
        wait_cyc(per - hi);
    endtask

    task automatic disable_now();
        enable = 1'b0;
        while (ev_q.size() > 0 && ev_q[$].c > cyc) void'(ev_q.pop_back());
        have_prev = 1'b0;
        last_acc  = -100000;
    endtask

    initial begin
        int per, hi;
        reset_n = 1'b0; enable = 1'b0; pwm_in = 1'b0;
        cyc = 0; n_cmp = 0; n_fail = 0; mdl_angle = 12'd0;
        have_prev = 1'b0; prev_rise = 0; fall_cyc = 0; last_acc = -100000;
        repeat (3) @(posedge clock);
        #1;
        chk("reset_angle", angle, 0);
        chk("reset_valid", angle_valid, 0);
        chk("reset_locked", locked, 0);
        chk("reset_fault", fault, 0);
        chk("reset_overrun", overrun, 0);
        reset_n = 1'b1;
        enable  = 1'b1;

        // Hand-computed frames pin the model: q = hi*4351/per, angle = clamp(q-128).
        frame(228, 4351);
        frame(128, 4351);
        chk("lit_angle_100", angle, 100);
        chk("lit_locked", locked, 1);
        frame(4223, 4351);
        chk("lit_angle_header", angle, 0);
        frame(100, 4351);
        chk("lit_angle_4095", angle, 4095);
        frame(4300, 4351);
        chk("lit_clamp_low", angle, 0);
        frame(50, 200);
        chk("lit_clamp_high", angle, 4095);

        // Glitch frame is dropped; the following frame decodes normally.
        frame(5, 10);
        frame(300, 500);
        frame(300, 500);
        chk("lit_after_glitch", angle, 2482);

        // Frame closing while the divider is busy.
        frame(10, 25);
        frame(200, 400);
        frame(200, 400);

        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 9) == 0) per = $urandom_range(4, 40);
            else per = $urandom_range(100, 700);
            hi = $urandom_range(1, per - 1);
            frame(hi, per);
        end

        // Stuck-low input trips the watchdog; two edges are needed to recover.
        wait_cyc(TMO + 500);
        have_prev = 1'b0;
        chk("stuck_fault", fault, 1);
        chk("stuck_locked", locked, 0);
        frame(300, 500);
        chk("recover_fault_held", fault, 1);
        frame(300, 500);
        chk("recover_fault_clear", fault, 0);
        chk("recover_locked", locked, 1);
        chk("recover_angle", angle, 2482);

        // Enable drop mid-division.
        frame(100, 500);
        drive_pwm(1'b1);
        wait_cyc(15);
        disable_now();
        drive_pwm(1'b0);
        wait_cyc(10);
        chk("abort_locked", locked, 0);
        chk("abort_angle_held", angle, 2482);
        enable = 1'b1;
        wait_cyc(5);
        frame(400, 600);
        frame(400, 600);
        frame(150, 600);
        chk("resume_angle", angle, 2772);

        // Enable drop in the very cycle the divider would complete.
        drive_pwm(1'b1);
        wait_cyc(LAT - 1);
        disable_now();
        drive_pwm(1'b0);
        wait_cyc(4);
        chk("abort_edge_angle", angle, 2772);
        chk("abort_edge_locked", locked, 0);
        enable = 1'b1;
        wait_cyc(5);
        frame(300, 500);
        frame(300, 500);

        // Asynchronous reset mid-division.
        drive_pwm(1'b1);
        wait_cyc(20);
        reset_n = 1'b0;
        pwm_in  = 1'b0;
        ev_q.delete();
        ov_q.delete();
        have_prev = 1'b0;
        last_acc  = -100000;
        #1;
        chk("midrst_angle", angle, 0);
        chk("midrst_valid", angle_valid, 0);
        chk("midrst_locked", locked, 0);
        chk("midrst_fault", fault, 0);
        chk("midrst_overrun", overrun, 0);
        wait_cyc(3);
        reset_n = 1'b1;
        wait_cyc(5);
        frame(300, 500);
        frame(300, 500);
        frame(300, 500);
        chk("post_rst_angle", angle, 2482);
        chk("post_rst_locked", locked, 1);
        wait_cyc(60);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
